stage_ex_md: RTL and testbench

//  Parametrised next-generation execute stage. It sits between decode and memory in the

---
 rtl/stage_ex_md_if.sv | 36 +++
 rtl/stage_ex_md.sv | 197 +++++++++++++++++++
 tb/tb_stage_ex_md.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stage_ex_md_if.sv
// stage_ex_md_if: decode-to-execute valid/ready instruction bundle.
// Decode drives the master side, the execute stage takes the slave side.
interface stage_ex_md_if #(
  parameter int XLEN = 32,
  parameter int RIDX = 5
);
  logic            id_valid;
  logic            id_ready;
  logic [3:0]      id_op;
  logic [XLEN-1:0] id_op1;
  logic [XLEN-1:0] id_op2;
  logic [RIDX-1:0] id_rd;
  logic            id_w_rd;
  logic            id_w_flags;
  logic            id_r_flags;
  logic [2:0]      id_cond;
  logic            id_branch;
  logic [XLEN-1:0] id_bdest;
  logic [RIDX-1:0] id_rs3;
  logic            id_mem_w;
  logic [1:0]      id_mem_sz;

  modport master (
    output id_valid, id_op, id_op1, id_op2, id_rd,
    output id_w_rd, id_w_flags, id_r_flags, id_cond,
    output id_branch, id_bdest, id_rs3, id_mem_w, id_mem_sz,
    input  id_ready
  );

  modport slave (
    input  id_valid, id_op, id_op1, id_op2, id_rd,
    input  id_w_rd, id_w_flags, id_r_flags, id_cond,
    input  id_branch, id_bdest, id_rs3, id_mem_w, id_mem_sz,
    output id_ready
  );
endinterface

// File: rtl/stage_ex_md.sv
// stage_ex_md: execute stage with valid/ready intake, iterative mul/div,
// flush, condition flags and MEM/WB store-data forwarding.
module stage_ex_md #(
  parameter int XLEN    = 32,
  parameter int RIDX    = 5,
  parameter int MD_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  stage_ex_md_if.slave    id,
  input  logic            fl_flush,
  input  logic            mem_w_rd,
  input  logic [RIDX-1:0] mem_rd,
  input  logic [XLEN-1:0] mem_res,
  input  logic            wb_w_rd,
  input  logic [RIDX-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_res,
  input  logic [XLEN-1:0] rf_rs3_data,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_res,
  output logic [RIDX-1:0] ex_rd,
  output logic            ex_w_rd,
  output logic [XLEN-1:0] ex_op3,
  output logic            ex_mem_w,
  output logic [1:0]      ex_mem_sz,
  output logic            ex_branch,
  output logic [XLEN-1:0] ex_bdest,
  output logic [1:0]      ex_flags
);
  localparam int CYC = XLEN / MD_STEP;
  localparam int CW  = $clog2(CYC + 1);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_MUL   = 4'd5;
  localparam logic [3:0] OP_MULHU = 4'd6;
  localparam logic [3:0] OP_DIVU  = 4'd7;
  localparam logic [3:0] OP_REMU  = 4'd8;

  logic              valid_q, busy_q;
  logic [CW-1:0]     cnt_q;
  logic [1:0]        flags_q, flags_d;
  logic [3:0]        op_q;
  logic [XLEN-1:0]   op1_q, op2_q, bdest_q;
  logic [RIDX-1:0]   rd_q, rs3_q;
  logic              w_rd_q, wflags_q, rflags_q;
  logic [2:0]        cond_q;
  logic              branch_q, mem_w_q;
  logic [1:0]        mem_sz_q;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   sh_q, sh_d;

  logic            cap, md_op, mul_q, ex_v, cond_true, flag_we;
  logic [XLEN:0]   rem;
  logic [XLEN-1:0] res, src, op3;

  assign md_op     = (id.id_op >= OP_MUL) && (id.id_op <= OP_REMU);
  assign mul_q     = (op_q == OP_MUL) || (op_q == OP_MULHU);
  assign id.id_ready = rst || !busy_q;
  assign cap       = id.id_valid && id.id_ready && !fl_flush;
  assign ex_v      = !rst && valid_q && !busy_q;
  assign cond_true = !rflags_q ||
                     ((cond_q[2:1] == flags_q) ^ cond_q[0]);
  assign flag_we   = ex_v && (op_q == OP_SUB) &&
                     wflags_q && !fl_flush;

  always_comb begin
    flags_d = 2'b10;
    if (op1_q == op2_q) flags_d = 2'b00;
    else if (op1_q < op2_q) flags_d = 2'b01;
  end

  // MSB-first shift-add multiply / restoring divide, MD_STEP bits per edge.
  // Divide keeps the partial remainder in acc and the quotient in sh.
  always_comb begin
    acc_d = acc_q;
    sh_d  = sh_q;
    rem   = '0;
    for (int i = 0; i < MD_STEP; i++) begin
      if (mul_q) begin
        acc_d = acc_d << 1;
        if (sh_d[XLEN-1])
          acc_d = acc_d + {{XLEN{1'b0}}, op1_q};
        sh_d = sh_d << 1;
      end else begin
        rem  = {acc_d[XLEN-1:0], sh_d[XLEN-1]};
        sh_d = sh_d << 1;
        if (rem >= {1'b0, op2_q}) begin
          rem     = rem - {1'b0, op2_q};
          sh_d[0] = 1'b1;
        end
        acc_d = {{XLEN{1'b0}}, rem[XLEN-1:0]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      flags_q  <= 2'b00;
      op_q     <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      rd_q     <= '0;
      w_rd_q   <= 1'b0;
      wflags_q <= 1'b0;
      rflags_q <= 1'b0;
      cond_q   <= '0;
      branch_q <= 1'b0;
      bdest_q  <= '0;
      rs3_q    <= '0;
      mem_w_q  <= 1'b0;
      mem_sz_q <= '0;
      acc_q    <= '0;
      sh_q     <= '0;
    end else begin
      if (flag_we) flags_q <= flags_d;
      if (fl_flush) begin
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
        cnt_q   <= '0;
      end else if (cap) begin
        valid_q  <= 1'b1;
        busy_q   <= md_op;
        cnt_q    <= md_op ? CW'(CYC) : '0;
        op_q     <= id.id_op;
        op1_q    <= id.id_op1;
        op2_q    <= id.id_op2;
        rd_q     <= id.id_rd;
        w_rd_q   <= id.id_w_rd;
        wflags_q <= id.id_w_flags;
        rflags_q <= id.id_r_flags;
        cond_q   <= id.id_cond;
        branch_q <= id.id_branch;
        bdest_q  <= id.id_bdest;
        rs3_q    <= id.id_rs3;
        mem_w_q  <= id.id_mem_w;
        mem_sz_q <= id.id_mem_sz;
        acc_q    <= '0;
        sh_q     <= (id.id_op == OP_MUL || id.id_op == OP_MULHU)
                    ? id.id_op2 : id.id_op1;
      end else if (busy_q) begin
        acc_q <= acc_d;
        sh_q  <= sh_d;
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) busy_q <= 1'b0;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    case (op_q)
      OP_SUB:   res = op1_q - op2_q;
      OP_AND:   res = op1_q & op2_q;
      OP_OR:    res = op1_q | op2_q;
      OP_XOR:   res = op1_q ^ op2_q;
      OP_MUL:   res = acc_q[XLEN-1:0];
      OP_MULHU: res = acc_q[2*XLEN-1:XLEN];
      OP_DIVU:  res = sh_q;
      OP_REMU:  res = acc_q[XLEN-1:0];
      default:  res = op1_q + op2_q;
    endcase
  end

  // MEM beats WB beats the register file; stores replicate into all lanes.
  always_comb begin
    src = rf_rs3_data;
    if (mem_w_rd && mem_rd == rs3_q) src = mem_res;
    else if (wb_w_rd && wb_rd == rs3_q) src = wb_res;
    op3 = src;
    if (mem_w_q) begin
      case (mem_sz_q)
        2'd0:    op3 = {(XLEN/8){src[7:0]}};
        2'd1:    op3 = {(XLEN/16){src[15:0]}};
        default: op3 = src;
      endcase
    end
  end

  assign ex_valid  = ex_v;
  assign ex_res    = ex_v ? res : '0;
  assign ex_rd     = ex_v ? rd_q : '0;
  assign ex_w_rd   = ex_v && w_rd_q && cond_true;
  assign ex_branch = ex_v && branch_q && cond_true;
  assign ex_bdest  = ex_v ? bdest_q : '0;
  assign ex_mem_w  = ex_v && mem_w_q;
  assign ex_mem_sz = ex_v ? mem_sz_q : '0;
  assign ex_op3    = ex_v ? op3 : '0;
  assign ex_flags  = flags_q;
endmodule

// File: tb/tb_stage_ex_md.sv
// tb_stage_ex_md: randomized bench for stage_ex_md against an arithmetic
// reference model; second instance runs MD_STEP=4.
module tb_stage_ex_md;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [1:0] mflags;

  stage_ex_md_if #(.XLEN(32), .RIDX(5)) ia();
  stage_ex_md_if #(.XLEN(32), .RIDX(5)) ib();

  logic        fl_flush, mem_w_rd, wb_w_rd;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_res, wb_res, rf_rs3_data;
  logic        ex_valid, ex_w_rd, ex_mem_w, ex_branch;
  logic [31:0] ex_res, ex_op3, ex_bdest;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_mem_sz, ex_flags;

  logic        b_valid, b_w_rd, b_mem_w, b_branch;
  logic [31:0] b_res, b_op3, b_bdest;
  logic [4:0]  b_rd;
  logic [1:0]  b_mem_sz, b_flags;

  stage_ex_md #(.XLEN(32), .RIDX(5), .MD_STEP(1)) dut (
    .clk(clk), .rst(rst), .id(ia), .fl_flush(fl_flush),
    .mem_w_rd(mem_w_rd), .mem_rd(mem_rd), .mem_res(mem_res),
    .wb_w_rd(wb_w_rd), .wb_rd(wb_rd), .wb_res(wb_res),
    .rf_rs3_data(rf_rs3_data),
    .ex_valid(ex_valid), .ex_res(ex_res), .ex_rd(ex_rd),
    .ex_w_rd(ex_w_rd), .ex_op3(ex_op3), .ex_mem_w(ex_mem_w),
    .ex_mem_sz(ex_mem_sz), .ex_branch(ex_branch),
    .ex_bdest(ex_bdest), .ex_flags(ex_flags)
  );

  stage_ex_md #(.XLEN(32), .RIDX(5), .MD_STEP(4)) dut4 (
    .clk(clk), .rst(rst), .id(ib), .fl_flush(1'b0),
    .mem_w_rd(1'b0), .mem_rd(5'd0), .mem_res(32'd0),
    .wb_w_rd(1'b0), .wb_rd(5'd0), .wb_res(32'd0),
    .rf_rs3_data(32'd0),
    .ex_valid(b_valid), .ex_res(b_res), .ex_rd(b_rd),
    .ex_w_rd(b_w_rd), .ex_op3(b_op3), .ex_mem_w(b_mem_w),
    .ex_mem_sz(b_mem_sz), .ex_branch(b_branch),
    .ex_bdest(b_bdest), .ex_flags(b_flags)
  );

  function automatic logic [31:0] ref_res(input logic [3:0] op,
                                          input logic [31:0] a, b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return p[31:0];
      4'd6:    return p[63:32];
      4'd7:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd8:    return (b == 0) ? a : a % b;
      default: return a + b;
    endcase
  endfunction

  function automatic logic [1:0] ref_cmp(input logic [31:0] a, b);
    if (a == b) return 2'b00;
    if (a < b) return 2'b01;
    return 2'b10;
  endfunction

  function automatic bit ref_cond(input bit rf, input logic [2:0] c,
                                  input logic [1:0] f);
    return !rf || ((c[2:1] == f) ^ c[0]);
  endfunction

  task automatic clr();
    ia.id_valid = 0; ia.id_op = 0; ia.id_op1 = 0; ia.id_op2 = 0;
    ia.id_rd = 0; ia.id_w_rd = 0; ia.id_w_flags = 0;
    ia.id_r_flags = 0; ia.id_cond = 0; ia.id_branch = 0;
    ia.id_bdest = 0; ia.id_rs3 = 0; ia.id_mem_w = 0; ia.id_mem_sz = 0;
  endtask

  task automatic clr_b();
    ib.id_valid = 0; ib.id_op = 0; ib.id_op1 = 0; ib.id_op2 = 0;
    ib.id_rd = 0; ib.id_w_rd = 0; ib.id_w_flags = 0;
    ib.id_r_flags = 0; ib.id_cond = 0; ib.id_branch = 0;
    ib.id_bdest = 0; ib.id_rs3 = 0; ib.id_mem_w = 0; ib.id_mem_sz = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, b);
    ia.id_op = op; ia.id_op1 = a; ia.id_op2 = b; ia.id_valid = 1'b1;
    step();
    ia.id_valid = 1'b0;
  endtask

  // k counts cycles after the capture edge; k=1 is a single-cycle op.
  task automatic wait_res(output logic [31:0] r, output int lat,
                          output int stalls, output bit ok);
    r = '0; lat = 0; stalls = 0; ok = 0;
    for (int k = 1; k <= 80; k++) begin
      if (!ia.id_ready) stalls++;
      if (ex_valid) begin
        r = ex_res; lat = k; ok = 1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1; clr(); clr_b(); fl_flush = 0;
    mem_w_rd = 0; mem_rd = 0; mem_res = 0;
    wb_w_rd = 0; wb_rd = 0; wb_res = 0; rf_rs3_data = 0;
    ia.id_valid = 1; ia.id_w_rd = 1; ia.id_branch = 1; ia.id_mem_w = 1;
    #1;
    total++;
    if (ia.id_ready !== 1'b1 || ex_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_pre ready=%b valid=%b want 1/0",
               ia.id_ready, ex_valid);
    end
    step();
    total++;
    if ({ex_valid, ex_w_rd, ex_branch, ex_mem_w} !== 4'b0000 ||
        ia.id_ready !== 1'b1 || ex_flags !== 2'b00) begin
      bad++;
      $display("FAIL reset_outs v/w/b/m=%b%b%b%b rdy=%b fl=%b want 0000/1/00",
               ex_valid, ex_w_rd, ex_branch, ex_mem_w, ia.id_ready, ex_flags);
    end
    rst = 0; clr();
    step();
    total++;
    if (ex_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_nocap valid=%b want 0", ex_valid);
    end
    mflags = 2'b00;
  endtask

  task automatic test_flags_branch();
    clr(); ia.id_w_flags = 1;
    issue(4'd1, 32'd3, 32'd5);
    total++;
    if (ex_valid !== 1'b1 || ex_res !== 32'hFFFF_FFFE) begin
      bad++;
      $display("FAIL sub_res valid=%b got=%h want=fffffffe", ex_valid, ex_res);
    end
    issue(4'd1, 32'd5, 32'd5);
    total++;
    if (ex_flags !== 2'b01) begin
      bad++;
      $display("FAIL flags_lt got=%b want=01", ex_flags);
    end
    ia.id_w_flags = 0; ia.id_r_flags = 1; ia.id_cond = 3'b000;
    ia.id_branch = 1; ia.id_bdest = 32'h100; ia.id_w_rd = 1; ia.id_rd = 7;
    issue(4'd0, 32'd1, 32'd1);
    total++;
    if (ex_flags !== 2'b00 || ex_branch !== 1'b1 ||
        ex_bdest !== 32'h100 || ex_w_rd !== 1'b1) begin
      bad++;
      $display("FAIL br_taken fl=%b br=%b dest=%h w=%b want 00/1/100/1",
               ex_flags, ex_branch, ex_bdest, ex_w_rd);
    end
    ia.id_cond = 3'b001; ia.id_bdest = 32'h200;
    issue(4'd0, 32'd1, 32'd1);
    total++;
    if (ex_branch !== 1'b0 || ex_w_rd !== 1'b0 || ex_valid !== 1'b1) begin
      bad++;
      $display("FAIL br_not br=%b w=%b v=%b want 0/0/1",
               ex_branch, ex_w_rd, ex_valid);
    end
    clr(); step();
    total++;
    if (ex_valid !== 0 || ex_branch !== 0 || ex_w_rd !== 0 ||
        ex_bdest !== 0 || ex_res !== 0) begin
      bad++;
      $display("FAIL bubble v=%b br=%b w=%b dest=%h res=%h want zeros",
               ex_valid, ex_branch, ex_w_rd, ex_bdest, ex_res);
    end
    mflags = 2'b00;
  endtask

  task automatic test_muldiv();
    logic [3:0]  ops [6] = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd7, 4'd8};
    logic [31:0] av  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd7,
                             32'd100, 32'd100};
    logic [31:0] bv  [6] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'd7, 32'd7};
    logic [31:0] ev  [6] = '{32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFF, 32'd7,
                             32'd14, 32'd2};
    logic [31:0] r;
    int lat, st;
    bit ok;
    for (int i = 0; i < 6; i++) begin
      clr();
      issue(ops[i], av[i], bv[i]);
      wait_res(r, lat, st, ok);
      total++;
      if (!ok || r !== ev[i]) begin
        bad++;
        $display("FAIL md_res[%0d] got=%h want=%h seen=%0d", i, r, ev[i], ok);
      end
      total++;
      if (lat != 33 || st != 32) begin
        bad++;
        $display("FAIL md_lat[%0d] lat=%0d stalls=%0d want 33/32", i, lat, st);
      end
      step();
      total++;
      if (ex_valid !== 1'b0) begin
        bad++;
        $display("FAIL md_pulse[%0d] valid=%b want 0", i, ex_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a, b, r;
    int lat, st, el;
    bit ok, cw;
    for (int i = 0; i < 40; i++) begin
      clr();
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      ia.id_rd = 5'($urandom); ia.id_w_rd = 1'($urandom);
      ia.id_w_flags = 1'($urandom); ia.id_r_flags = 1'($urandom);
      ia.id_cond = 3'($urandom);
      issue(op, a, b);
      wait_res(r, lat, st, ok);
      el = (op >= 5 && op <= 8) ? 33 : 1;
      cw = ia.id_w_rd && ref_cond(ia.id_r_flags, ia.id_cond, mflags);
      total++;
      if (!ok || r !== ref_res(op, a, b) || lat != el) begin
        bad++;
        $display("FAIL rnd_res[%0d] op=%0d got=%h want=%h lat=%0d want=%0d",
                 i, op, r, ref_res(op, a, b), lat, el);
      end
      total++;
      if (ex_w_rd !== cw || ex_rd !== ia.id_rd || ex_flags !== mflags) begin
        bad++;
        $display("FAIL rnd_ctl[%0d] w=%b rd=%0d fl=%b want %b/%0d/%b",
                 i, ex_w_rd, ex_rd, ex_flags, cw, ia.id_rd, mflags);
      end
      if (op == 4'd1 && ia.id_w_flags) mflags = ref_cmp(a, b);
    end
    clr(); step();
  endtask

  task automatic test_flush();
    int n;
    clr(); ia.id_w_flags = 1;
    issue(4'd1, 32'd9, 32'd2);
    clr(); step();
    mflags = 2'b10;
    total++;
    if (ex_flags !== mflags) begin
      bad++;
      $display("FAIL flush_pre fl=%b want=%b", ex_flags, mflags);
    end
    issue(4'd7, 32'd100, 32'd7);
    repeat (22) step();
    fl_flush = 1; ia.id_valid = 1; ia.id_op = 4'd0; ia.id_w_rd = 1;
    step();
    fl_flush = 0; ia.id_valid = 0;
    total++;
    if (ex_valid !== 1'b0 || ia.id_ready !== 1'b1 || ex_flags !== mflags) begin
      bad++;
      $display("FAIL flush_md v=%b rdy=%b fl=%b want 0/1/%b",
               ex_valid, ia.id_ready, ex_flags, mflags);
    end
    n = 0;
    repeat (40) begin step(); if (ex_valid) n++; end
    total++;
    if (n != 0) begin
      bad++;
      $display("FAIL flush_md_late pulses=%0d want 0", n);
    end
    ia.id_valid = 1; fl_flush = 1;
    step();
    ia.id_valid = 0; fl_flush = 0;
    total++;
    if (ex_valid !== 1'b0 || ex_w_rd !== 1'b0 || ia.id_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_prio v=%b w=%b rdy=%b want 0/0/1",
               ex_valid, ex_w_rd, ia.id_ready);
    end
    clr(); ia.id_w_flags = 1;
    issue(4'd1, 32'd1, 32'd2);
    fl_flush = 1;
    step();
    fl_flush = 0;
    total++;
    if (ex_flags !== mflags) begin
      bad++;
      $display("FAIL flush_flag fl=%b want=%b", ex_flags, mflags);
    end
    clr();
    issue(4'd7, 32'd100, 32'd7);
    repeat (10) step();
    rst = 1;
    step();
    rst = 0; #1;
    mflags = 2'b00;
    total++;
    if (ex_valid !== 1'b0 || ia.id_ready !== 1'b1 || ex_flags !== 2'b00) begin
      bad++;
      $display("FAIL rst_md v=%b rdy=%b fl=%b want 0/1/00",
               ex_valid, ia.id_ready, ex_flags);
    end
    n = 0;
    repeat (40) begin step(); if (ex_valid) n++; end
    total++;
    if (n != 0) begin
      bad++;
      $display("FAIL rst_md_late pulses=%0d want 0", n);
    end
  endtask

  task automatic test_forward();
    logic [31:0] s, e;
    clr(); ia.id_mem_w = 1; ia.id_mem_sz = 0; ia.id_rs3 = 4;
    mem_w_rd = 1; mem_rd = 4; mem_res = 32'h1234_56AB;
    wb_w_rd = 1; wb_rd = 4; wb_res = 0; rf_rs3_data = 32'hDEAD_BEEF;
    issue(4'd0, 0, 0);
    total++;
    if (ex_op3 !== 32'hABAB_ABAB || ex_mem_w !== 1'b1 || ex_mem_sz !== 2'd0) begin
      bad++;
      $display("FAIL fwd_byte op3=%h mw=%b sz=%0d want abababab/1/0",
               ex_op3, ex_mem_w, ex_mem_sz);
    end
    for (int i = 0; i < 20; i++) begin
      clr();
      ia.id_rs3 = 5'($urandom_range(0, 3));
      ia.id_mem_w = 1'($urandom);
      ia.id_mem_sz = 2'($urandom_range(0, 2));
      mem_w_rd = 1'($urandom); mem_rd = 5'($urandom_range(0, 3));
      wb_w_rd = 1'($urandom); wb_rd = 5'($urandom_range(0, 3));
      mem_res = $urandom; wb_res = $urandom; rf_rs3_data = $urandom;
      issue(4'd0, 0, 0);
      if (mem_w_rd && mem_rd == ia.id_rs3) s = mem_res;
      else if (wb_w_rd && wb_rd == ia.id_rs3) s = wb_res;
      else s = rf_rs3_data;
      if (!ia.id_mem_w) e = s;
      else if (ia.id_mem_sz == 0) e = {24'd0, s[7:0]} * 32'h0101_0101;
      else if (ia.id_mem_sz == 1) e = {16'd0, s[15:0]} * 32'h0001_0001;
      else e = s;
      total++;
      if (ex_op3 !== e || ex_mem_w !== ia.id_mem_w) begin
        bad++;
        $display("FAIL fwd_rnd[%0d] op3=%h mw=%b want %h/%b",
                 i, ex_op3, ex_mem_w, e, ia.id_mem_w);
      end
    end
    clr(); step();
    total++;
    if (ex_op3 !== 0 || ex_mem_w !== 0) begin
      bad++;
      $display("FAIL fwd_bubble op3=%h mw=%b want 0/0", ex_op3, ex_mem_w);
    end
    mem_w_rd = 0; wb_w_rd = 0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    int lat, st;
    bit ok;
    clr();
    issue(4'd5, 32'd3, 32'd4);
    wait_res(r, lat, st, ok);
    total++;
    if (!ok || r !== 32'd12 || ia.id_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_mul got=%h rdy=%b want 0000000c/1", r, ia.id_ready);
    end
    issue(4'd0, 32'd10, 32'd20);
    total++;
    if (ex_valid !== 1'b1 || ex_res !== 32'd30) begin
      bad++;
      $display("FAIL b2b_add v=%b got=%h want 1/1e", ex_valid, ex_res);
    end
    issue(4'd7, 32'd1000, 32'd9);
    wait_res(r, lat, st, ok);
    issue(4'd8, 32'd1000, 32'd9);
    wait_res(r, lat, st, ok);
    total++;
    if (!ok || r !== 32'd1 || lat != 33) begin
      bad++;
      $display("FAIL b2b_div got=%h lat=%0d want 1/33", r, lat);
    end
    clr(); step();
  endtask

  task automatic test_step4();
    logic [3:0]  op;
    logic [31:0] a, b, r;
    int lat, st;
    for (int i = 0; i < 8; i++) begin
      clr_b();
      if (i < 2) begin
        op = (i == 0) ? 4'd6 : 4'd5;
        a = 32'h0001_0000; b = 32'h0001_0000;
      end else begin
        op = 4'($urandom_range(5, 8));
        a = $urandom;
        b = (i == 2) ? 32'd0 : $urandom >> $urandom_range(0, 28);
      end
      ib.id_op = op; ib.id_op1 = a; ib.id_op2 = b; ib.id_valid = 1;
      step();
      ib.id_valid = 0;
      lat = 0; st = 0; r = 'x;
      for (int k = 1; k <= 30; k++) begin
        if (!ib.id_ready) st++;
        if (b_valid) begin r = b_res; lat = k; break; end
        step();
      end
      total++;
      if (r !== ref_res(op, a, b) || lat != 9 || st != 8) begin
        bad++;
        $display("FAIL step4[%0d] op=%0d got=%h want=%h lat=%0d st=%0d want 9/8",
                 i, op, r, ref_res(op, a, b), lat, st);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_flags_branch();
    test_muldiv();
    test_random();
    test_flush();
    test_forward();
    test_back_to_back();
    test_step4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
